// File: rtl/chipset_io_bus_controller_if.sv
// CPU-side I/O cycle bundle between the bus/command logic and the chip-select controller.
// CHANNEL_READY_EN adds the per-channel ready inputs and the timeout flag.
interface chipset_io_bus_controller_if #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int WAIT_WIDTH = 4
);
    localparam int CH_BITS = $clog2(CHANNELS);

    logic                           address_enable_n;
    logic                           io_read_command_n;
    logic                           io_write_command_n;
    logic [ADDR_WIDTH-1:0]          address;
    logic [CHANNELS*WAIT_WIDTH-1:0] wait_states;
    logic [CHANNELS*DATA_WIDTH-1:0] channel_data_in;
    logic [CHANNELS-1:0]            chip_select_n;
    logic [DATA_WIDTH-1:0]          data_bus_out;
    logic                           data_bus_out_from_chipset;
    logic                           io_ready;
    logic [CH_BITS-1:0]             active_channel;
`ifdef CHANNEL_READY_EN
    logic [CHANNELS-1:0]            channel_ready;
    logic                           bus_timeout;
`endif

    // Bus/command side and peripherals drive the cycle.
    modport master (
`ifdef CHANNEL_READY_EN
        output channel_ready, input bus_timeout,
`endif
        output address_enable_n, io_read_command_n, io_write_command_n, address,
        output wait_states, channel_data_in,
        input  chip_select_n, data_bus_out, data_bus_out_from_chipset, io_ready, active_channel
    );

    // The controller decodes and answers.
    modport slave (
`ifdef CHANNEL_READY_EN
        input channel_ready, output bus_timeout,
`endif
        input  address_enable_n, io_read_command_n, io_write_command_n, address,
        input  wait_states, channel_data_in,
        output chip_select_n, data_bus_out, data_bus_out_from_chipset, io_ready, active_channel
    );
endinterface

// File: rtl/chipset_io_bus_controller.sv
// I/O cycle front end: address decode to N chip selects, per-channel wait states, read data latch.
// Define CHANNEL_READY_EN to add a READY_WAIT phase gated by channel_ready with a bus timeout.
module chipset_io_bus_controller #(
    parameter int CHANNELS       = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int BLOCK_SHIFT    = 5,
    parameter int BASE_ADDR      = 0,
    parameter int WAIT_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    chipset_io_bus_controller_if.slave bus
);
    localparam int CH_BITS   = $clog2(CHANNELS);
    localparam int UPPER_LSB = BLOCK_SHIFT + CH_BITS;
    localparam int UPPER_W   = ADDR_WIDTH - UPPER_LSB;
    localparam logic [UPPER_W-1:0] BASE_UPPER = UPPER_W'(BASE_ADDR);

`ifdef CHANNEL_READY_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_READY_WAIT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
`endif

    state_t                r_state;
    logic [WAIT_WIDTH-1:0] r_count;
    logic                  r_is_read;
    logic [CH_BITS-1:0]    r_channel;
    logic [CHANNELS-1:0]   r_cs_n;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_from_chipset;
    logic                  r_io_ready;
`ifdef CHANNEL_READY_EN
    logic [TIMER_W-1:0]    r_timer;
    logic                  r_timeout;
`endif

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_strobes_idle;
    logic                  w_hit;
    logic [CH_BITS-1:0]    w_channel;
    logic [WAIT_WIDTH-1:0] w_wait;
    logic [DATA_WIDTH-1:0] w_new_data;
    logic [DATA_WIDTH-1:0] w_active_data;
    logic                  w_unused_cfg;

    assign w_rd           = ~bus.io_read_command_n;
    assign w_wr           = ~bus.io_write_command_n;
    assign w_strobes_idle = bus.io_read_command_n & bus.io_write_command_n;
    assign w_channel      = bus.address[BLOCK_SHIFT +: CH_BITS];
    // Exactly one strobe must be active; a DMA-owned bus is never decoded.
    assign w_hit          = ~bus.address_enable_n
                          & (bus.address[ADDR_WIDTH-1:UPPER_LSB] == BASE_UPPER)
                          & (w_rd ^ w_wr);
    assign w_wait         = bus.wait_states[int'(w_channel)*WAIT_WIDTH +: WAIT_WIDTH];
    assign w_new_data     = bus.channel_data_in[int'(w_channel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_active_data  = bus.channel_data_in[int'(r_channel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_unused_cfg   = ^{bus.address[BLOCK_SHIFT-1:0], 1'(TIMEOUT_CYCLES)};

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_is_read      <= 1'b0;
            r_channel      <= '0;
            r_cs_n         <= '1;
            r_data         <= '0;
            r_from_chipset <= 1'b0;
            r_io_ready     <= 1'b1;
`ifdef CHANNEL_READY_EN
            r_timer        <= '0;
            r_timeout      <= 1'b0;
`endif
        end else begin
`ifdef CHANNEL_READY_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_cs_n    <= ~(CHANNELS'(1) << w_channel);
                        r_channel <= w_channel;
                        r_count   <= w_wait;
                        r_is_read <= w_rd;
                        if (w_wait != '0) begin
                            r_state    <= ST_WAIT;
                            r_io_ready <= 1'b0;
                        end else begin
`ifdef CHANNEL_READY_EN
                            r_state    <= ST_READY_WAIT;
                            r_io_ready <= 1'b0;
                            r_timer    <= '0;
`else
                            r_state <= ST_DONE;
                            if (w_rd) begin
                                r_data         <= w_new_data;
                                r_from_chipset <= 1'b1;
                            end
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - WAIT_WIDTH'(1);
                    if (w_strobes_idle) begin
                        r_state    <= ST_IDLE;
                        r_cs_n     <= '1;
                        r_io_ready <= 1'b1;
                    end else if (r_count == WAIT_WIDTH'(1)) begin
`ifdef CHANNEL_READY_EN
                        r_state <= ST_READY_WAIT;
                        r_timer <= '0;
`else
                        r_state    <= ST_DONE;
                        r_io_ready <= 1'b1;
                        if (r_is_read) begin
                            r_data         <= w_active_data;
                            r_from_chipset <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CHANNEL_READY_EN
                ST_READY_WAIT: begin
                    if (w_strobes_idle) begin
                        r_state    <= ST_IDLE;
                        r_cs_n     <= '1;
                        r_io_ready <= 1'b1;
                    end else if (bus.channel_ready[r_channel]
                                 || r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state    <= ST_DONE;
                        r_io_ready <= 1'b1;
                        r_timeout  <= ~bus.channel_ready[r_channel];
                        if (r_is_read) begin
                            r_data         <= w_active_data;
                            r_from_chipset <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
`endif
                ST_DONE: begin
                    if (w_strobes_idle) begin
                        r_state        <= ST_IDLE;
                        r_cs_n         <= '1;
                        r_from_chipset <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.chip_select_n             = r_cs_n;
    assign bus.data_bus_out              = r_data;
    assign bus.data_bus_out_from_chipset = r_from_chipset;
    assign bus.io_ready                  = r_io_ready;
    assign bus.active_channel            = r_channel;
`ifdef CHANNEL_READY_EN
    assign bus.bus_timeout               = r_timeout;
`endif
endmodule

// File: tb/tb_chipset_io_bus_controller.sv
// Scoreboard bench for chipset_io_bus_controller: each bus cycle's expected outcome is queued
// from a behavioural model when driven, then popped and compared against the observed cycle.
module tb_chipset_io_bus_controller;
    localparam int CHANNELS   = 8;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 8;
    localparam int WAIT_WIDTH = 4;
`ifdef CHANNEL_READY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [7:0] cs_and;
        logic [7:0] low;
        logic [7:0] data;
        logic [2:0] act;
        logic       from_last;
        logic       from_any;
        logic [7:0] cs_rel;
        logic       rdy_rel;
        logic       from_rel;
        logic [7:0] data_rel;
    } obs_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    logic [3:0] ws [CHANNELS];
    logic [7:0] cd [CHANNELS];
    logic [7:0] m_data = 8'h00;
    logic [2:0] m_act  = 3'd0;
    obs_t       q_exp[$];

    chipset_io_bus_controller_if #(
        .CHANNELS(CHANNELS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .WAIT_WIDTH(WAIT_WIDTH)
    ) bus ();

    chipset_io_bus_controller #(
        .CHANNELS(CHANNELS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BLOCK_SHIFT(5), .BASE_ADDR(0), .WAIT_WIDTH(WAIT_WIDTH), .TIMEOUT_CYCLES(32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic string fmt(input obs_t o);
        return $sformatf("cs=%h low=%0d data=%h act=%0d from_last=%b from_any=%b rel_cs=%h rel_rdy=%b rel_from=%b rel_data=%h",
                         o.cs_and, o.low, o.data, o.act, o.from_last, o.from_any,
                         o.cs_rel, o.rdy_rel, o.from_rel, o.data_rel);
    endfunction

    task automatic apply_cfg();
        for (int c = 0; c < CHANNELS; c++) begin
            bus.wait_states[c*WAIT_WIDTH +: WAIT_WIDTH]     = ws[c];
            bus.channel_data_in[c*DATA_WIDTH +: DATA_WIDTH] = cd[c];
        end
    endtask

    // Behavioural model: strobes held for `hold` observed clocks, then released.
    task automatic expect_cycle(input bit aen, input bit rd, input bit wr,
                                input logic [9:0] addr, input int hold);
        obs_t e;
        int   ch  = int'(addr[7:5]);
        int   w   = int'(ws[ch]);
        bit   hit = !aen && (addr[9:8] == 2'b00) && (rd != wr);
        e.cs_and = 8'hFF; e.low = 8'd0; e.data = m_data; e.act = m_act;
        e.from_last = 1'b0; e.from_any = 1'b0;
        e.cs_rel = 8'hFF; e.rdy_rel = 1'b1; e.from_rel = 1'b0; e.data_rel = m_data;
        if (hit) begin
            e.cs_and = ~(8'h01 << ch);
            e.act    = 3'(ch);
            if (hold <= w + EXTRA) begin
                e.low = 8'(hold);
            end else begin
                e.low = 8'(w + EXTRA);
                if (rd) begin
                    e.data = cd[ch]; e.data_rel = cd[ch];
                    e.from_last = 1'b1; e.from_any = 1'b1;
                end
            end
        end
        m_data = e.data_rel;
        m_act  = e.act;
        q_exp.push_back(e);
    endtask

    task automatic bus_cycle(input bit aen, input bit rd, input bit wr, input logic [9:0] addr,
                             input int hold, input bit scramble, output obs_t o);
        logic [CHANNELS*WAIT_WIDTH-1:0] ws_save = bus.wait_states;
        @(negedge clock);
        bus.address_enable_n   = aen;
        bus.address            = addr;
        bus.io_read_command_n  = !rd;
        bus.io_write_command_n = !wr;
        o = '0;
        o.cs_and = 8'hFF;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clock);
            o.cs_and   = o.cs_and & bus.chip_select_n;
            o.low      = o.low + 8'(!bus.io_ready);
            o.from_any = o.from_any | bus.data_bus_out_from_chipset;
            if (k == hold) begin
                o.data      = bus.data_bus_out;
                o.act       = bus.active_channel;
                o.from_last = bus.data_bus_out_from_chipset;
            end
            if (scramble && k == 1) begin
                bus.address     = addr ^ 10'h0E0;
                bus.wait_states = $urandom;
            end
        end
        bus.io_read_command_n  = 1'b1;
        bus.io_write_command_n = 1'b1;
        bus.address_enable_n   = 1'b1;
        bus.wait_states        = ws_save;
        @(negedge clock);
        o.cs_rel   = bus.chip_select_n;
        o.rdy_rel  = bus.io_ready;
        o.from_rel = bus.data_bus_out_from_chipset;
        o.data_rel = bus.data_bus_out;
    endtask

    task automatic test_reset();
        @(negedge clock);
        @(negedge clock);
        checks++; if (bus.chip_select_n !== 8'hFF) begin errors++; $display("FAIL reset_cs: got %h required ff", bus.chip_select_n); end
        checks++; if (bus.io_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.io_ready); end
        checks++; if (bus.data_bus_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", bus.data_bus_out); end
        checks++; if (bus.data_bus_out_from_chipset !== 1'b0) begin errors++; $display("FAIL reset_from: got %b required 0", bus.data_bus_out_from_chipset); end
        checks++; if (bus.active_channel !== 3'd0) begin errors++; $display("FAIL reset_act: got %0d required 0", bus.active_channel); end
        reset_n = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        obs_t o, e;
        ws[1] = 4'd0; cd[1] = 8'hA5; apply_cfg();
        expect_cycle(1'b0, 1'b1, 1'b0, 10'h021, 4);
        bus_cycle(1'b0, 1'b1, 1'b0, 10'h021, 4, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL zero_wait_read: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_wait_write();
        obs_t o, e;
        ws[3] = 4'd3; cd[3] = 8'h5A; apply_cfg();
        expect_cycle(1'b0, 1'b0, 1'b1, 10'h061, 7);
        bus_cycle(1'b0, 1'b0, 1'b1, 10'h061, 7, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL wait_write: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_random_cycles();
        obs_t o, e;
        for (int i = 0; i < 6; i++) begin
            int         ch   = $urandom_range(0, CHANNELS - 1);
            bit         rd   = (i % 3) != 2;
            int         hold;
            logic [9:0] addr;
            ws[ch] = 4'($urandom_range(0, 15));
            cd[ch] = 8'($urandom);
            apply_cfg();
            addr = {2'b00, 3'(ch), 5'($urandom)};
            hold = int'(ws[ch]) + 2 + EXTRA + $urandom_range(0, 2);
            expect_cycle(1'b0, rd, !rd, addr, hold);
            bus_cycle(1'b0, rd, !rd, addr, hold, 1'b1, o);
            e = q_exp.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL random_cycle_%0d: got %s required %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_unmapped();
        obs_t o, e;
        expect_cycle(1'b1, 1'b1, 1'b0, 10'h040, 4);
        bus_cycle(1'b1, 1'b1, 1'b0, 10'h040, 4, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL dma_cycle: got %s required %s", fmt(o), fmt(e)); end
        expect_cycle(1'b0, 1'b1, 1'b0, 10'h3F0, 4);
        bus_cycle(1'b0, 1'b1, 1'b0, 10'h3F0, 4, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL base_miss: got %s required %s", fmt(o), fmt(e)); end
        expect_cycle(1'b0, 1'b1, 1'b1, 10'h021, 4);
        bus_cycle(1'b0, 1'b1, 1'b1, 10'h021, 4, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL both_strobes: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_abort();
        obs_t o, e;
        ws[4] = 4'd5; cd[4] = ~m_data; apply_cfg();
        expect_cycle(1'b0, 1'b1, 1'b0, 10'h081, 2);
        bus_cycle(1'b0, 1'b1, 1'b0, 10'h081, 2, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL abort: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        ws[5] = 4'd1; cd[5] = 8'h3C; ws[7] = 4'd2; cd[7] = 8'hC3; apply_cfg();
        expect_cycle(1'b0, 1'b1, 1'b0, 10'h0A0, 3 + EXTRA);
        bus_cycle(1'b0, 1'b1, 1'b0, 10'h0A0, 3 + EXTRA, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL b2b_read: got %s required %s", fmt(o), fmt(e)); end
        expect_cycle(1'b0, 1'b0, 1'b1, 10'h0E2, 4 + EXTRA);
        bus_cycle(1'b0, 1'b0, 1'b1, 10'h0E2, 4 + EXTRA, 1'b0, o);
        e = q_exp.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL b2b_write: got %s required %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_reset_mid_wait();
        ws[2] = 4'd5; apply_cfg();
        @(negedge clock);
        bus.address_enable_n = 1'b0; bus.address = 10'h040; bus.io_read_command_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (bus.io_ready !== 1'b0 || bus.chip_select_n !== 8'hFB) begin
            errors++; $display("FAIL pre_reset_wait: got ready=%b cs=%h required ready=0 cs=fb", bus.io_ready, bus.chip_select_n);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.chip_select_n !== 8'hFF) begin errors++; $display("FAIL async_reset_cs: got %h required ff", bus.chip_select_n); end
        checks++; if (bus.io_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b required 1", bus.io_ready); end
        checks++; if (bus.data_bus_out_from_chipset !== 1'b0) begin errors++; $display("FAIL async_reset_from: got %b required 0", bus.data_bus_out_from_chipset); end
        checks++; if (bus.data_bus_out !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h required 00", bus.data_bus_out); end
        bus.io_read_command_n = 1'b1; bus.address_enable_n = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        m_data = 8'h00; m_act = 3'd0;
    endtask

`ifdef CHANNEL_READY_EN
    task automatic test_ready_wait(input int raise_at, input int exp_low, input int exp_pulses);
        int low = 0, pulses = 0;
        ws[2] = 4'd2; cd[2] = 8'h96; apply_cfg();
        bus.channel_ready = '0;
        @(negedge clock);
        bus.address_enable_n = 1'b0; bus.address = 10'h040; bus.io_read_command_n = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            low    += int'(!bus.io_ready);
            pulses += int'(bus.bus_timeout);
            if (k == raise_at) bus.channel_ready = '1;
        end
        checks++; if (low !== exp_low) begin errors++; $display("FAIL ready_low_%0d: got %0d required %0d", raise_at, low, exp_low); end
        checks++; if (pulses !== exp_pulses) begin errors++; $display("FAIL timeout_pulse_%0d: got %0d required %0d", raise_at, pulses, exp_pulses); end
        checks++; if (bus.data_bus_out !== 8'h96) begin errors++; $display("FAIL ready_data_%0d: got %h required 96", raise_at, bus.data_bus_out); end
        bus.io_read_command_n = 1'b1; bus.address_enable_n = 1'b1; bus.channel_ready = '1;
        @(negedge clock);
        m_data = 8'h96; m_act = 3'd2;
    endtask
`endif

    initial begin
        for (int c = 0; c < CHANNELS; c++) begin ws[c] = 4'd0; cd[c] = 8'h00; end
        bus.address_enable_n   = 1'b1;
        bus.io_read_command_n  = 1'b1;
        bus.io_write_command_n = 1'b1;
        bus.address            = '0;
        apply_cfg();
`ifdef CHANNEL_READY_EN
        bus.channel_ready = '1;
`endif
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_random_cycles();
        test_unmapped();
        test_abort();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef CHANNEL_READY_EN
        test_ready_wait(100, 2 + 32, 1);
        test_ready_wait(4, 4, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
